// File: rtl/logic_unit_pkg.sv
// Shared types and helpers for the pipelined bitwise logic unit.
// Operation results are computed at full 64-bit width and truncated by the user.
package logic_unit_pkg;

  localparam int OP_W    = 3;
  localparam int COUNT_W = 16;
  localparam int MAX_W   = 64;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTA = 3'b110,
    OP_ANDN = 3'b111
  } op_e;

  function automatic logic [MAX_W-1:0] apply_op(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input op_e op);
    logic [MAX_W-1:0] res;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NAND: res = ~(a & b);
      OP_NOR:  res = ~(a | b);
      OP_XNOR: res = ~(a ^ b);
      OP_NOTA: res = ~a;
      OP_ANDN: res = a & ~b;
      default: res = {MAX_W{1'b0}};
    endcase
    return res;
  endfunction

  // Callers zero-extend narrower values, so the upper bits never affect the result.
  function automatic logic parity64(input logic [MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/logic_unit_stage.sv
// One elastic register stage: holds a valid bit and a PW-bit payload.
// It loads whenever it is empty or its current content leaves this cycle.
module logic_unit_stage #(
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [PW-1:0] in_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [PW-1:0] out_data
);

  logic          valid_q, valid_d;
  logic [PW-1:0] data_q, data_d;
  logic          load_s;

  // Next-state: take new content when free, otherwise hold.
  always_comb begin
    load_s  = (!valid_q) || out_ready;
    valid_d = valid_q;
    data_d  = data_q;
    if (load_s) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end else begin
        data_d = data_q;
      end
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
    end
  end

  // Stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= {PW{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined WIDTH-bit logic unit with valid/ready handshake and transfer counter.
// Define LOGIC_UNIT_FLAGS_EN to add the zero/parity flag outputs.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [OP_W-1:0]    op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   r,
`ifdef LOGIC_UNIT_FLAGS_EN
  output logic               zero,
  output logic               parity,
`endif
  output logic [COUNT_W-1:0] xfer_count
);

`ifdef LOGIC_UNIT_FLAGS_EN
  localparam int FLAG_W = 2;
`else
  localparam int FLAG_W = 0;
`endif
  localparam int PW = WIDTH + FLAG_W;

  logic [WIDTH-1:0]   res_s;
  logic [PW-1:0]      pay0_s;
  logic [STAGES-1:0]  stg_valid_s;
  logic [PW-1:0]      stg_data_s [STAGES];
  logic [STAGES-1:0]  load_s;
  logic               full_s;
  logic [COUNT_W-1:0] count_q, count_d;

  // Result and flags are formed once, at acceptance.
  always_comb begin
    res_s = WIDTH'(apply_op(MAX_W'(a), MAX_W'(b), op_e'(op)));
`ifdef LOGIC_UNIT_FLAGS_EN
    pay0_s = {(res_s == {WIDTH{1'b0}}), parity64(MAX_W'(res_s)), res_s};
`else
    pay0_s = res_s;
`endif
  end

  // Stage k can load unless it and every stage after it are full and the output is stalled.
  // Computed from the valid bits directly so there is no ripple through the stages.
  always_comb begin
    load_s = {STAGES{1'b0}};
    full_s = 1'b1;
    for (int k = 0; k < STAGES; k++) begin
      full_s = 1'b1;
      for (int j = k; j < STAGES; j++) begin
        full_s = full_s & stg_valid_s[j];
      end
      load_s[k] = (!full_s) || out_ready;
    end
  end

  assign in_ready = load_s[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic          dn_ready_s;
    logic          up_valid_s;
    logic [PW-1:0] up_data_s;

    if (k == 0) begin : g_first
      assign up_valid_s = in_valid;
      assign up_data_s  = pay0_s;
    end else begin : g_next
      assign up_valid_s = stg_valid_s[k-1];
      assign up_data_s  = stg_data_s[k-1];
    end

    if (k == STAGES - 1) begin : g_last
      assign dn_ready_s = out_ready;
    end else begin : g_mid
      assign dn_ready_s = load_s[k+1];
    end

    logic_unit_stage #(.PW(PW)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (up_valid_s),
      .in_data   (up_data_s),
      .out_ready (dn_ready_s),
      .out_valid (stg_valid_s[k]),
      .out_data  (stg_data_s[k])
    );
  end

  assign out_valid = stg_valid_s[STAGES-1];
  assign r         = stg_data_s[STAGES-1][WIDTH-1:0];
`ifdef LOGIC_UNIT_FLAGS_EN
  assign zero      = stg_data_s[STAGES-1][WIDTH+1];
  assign parity    = stg_data_s[STAGES-1][WIDTH];
`endif

  // Completed-transfer counter, free-running wrap.
  always_comb begin
    if (out_valid && out_ready) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign xfer_count = count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench: directed table for WIDTH=4/STAGES=2, plus random runs on
// WIDTH=1/STAGES=1 and WIDTH=64/STAGES=4 against a queue-based reference model.
module tb_logic_unit_pipe;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] r;
    logic       z;
    logic       p;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  iv, ordy;
  wire  [2:0]  ir, ov;
  logic [63:0] a_s [3];
  logic [63:0] b_s [3];
  logic [2:0]  op_s [3];
  logic [3:0]  r4;
  logic [0:0]  r1;
  logic [63:0] r64;
  logic [15:0] xc [3];
`ifdef LOGIC_UNIT_FLAGS_EN
  wire  [2:0]  zf, pf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(4), .STAGES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_s[0][3:0]), .b(b_s[0][3:0]), .op(op_s[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .r(r4),
`ifdef LOGIC_UNIT_FLAGS_EN
    .zero(zf[0]), .parity(pf[0]),
`endif
    .xfer_count(xc[0]));

  logic_unit_pipe #(.WIDTH(1), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_s[1][0:0]), .b(b_s[1][0:0]), .op(op_s[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .r(r1),
`ifdef LOGIC_UNIT_FLAGS_EN
    .zero(zf[1]), .parity(pf[1]),
`endif
    .xfer_count(xc[1]));

  logic_unit_pipe #(.WIDTH(64), .STAGES(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_s[2]), .b(b_s[2]), .op(op_s[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .r(r64),
`ifdef LOGIC_UNIT_FLAGS_EN
    .zero(zf[2]), .parity(pf[2]),
`endif
    .xfer_count(xc[2]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] rout(input int d);
    case (d)
      0:       return {60'd0, r4};
      1:       return {63'd0, r1};
      default: return r64;
    endcase
  endfunction

  function automatic int wd(input int d);
    case (d)
      0:       return 4;
      1:       return 1;
      default: return 64;
    endcase
  endfunction

  function automatic int st(input int d);
    case (d)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  // Reference: the eight operations from their definitions, masked to the width.
  function automatic logic [63:0] ref_op(input logic [63:0] x, input logic [63:0] y,
                                         input logic [2:0] o, input int w);
    logic [63:0] m, v;
    m = (w == 64) ? ~64'd0 : ((64'd1 << w) - 64'd1);
    case (o)
      3'd0:    v = x & y;
      3'd1:    v = x | y;
      3'd2:    v = x ^ y;
      3'd3:    v = ~(x & y);
      3'd4:    v = ~(x | y);
      3'd5:    v = ~(x ^ y);
      3'd6:    v = ~x;
      default: v = x & ~y;
    endcase
    return v & m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic [3:0] x, input logic [3:0] y, input logic [2:0] o);
    a_s[0]  = {60'd0, x};
    b_s[0]  = {60'd0, y};
    op_s[0] = o;
  endtask

  logic [63:0] mq [3][$];
  int          cnt [3];
  logic        prev_stall [3];
  logic [63:0] prev_r [3];

  initial begin
    vec_t tbl [11];
    int   n;
    bit   seen_ffff, seen_0001;

    tbl[0]  = '{4'b1100, 4'b1010, 3'b000, 4'b1000, 1'b0, 1'b1};
    tbl[1]  = '{4'b1100, 4'b1010, 3'b001, 4'b1110, 1'b0, 1'b1};
    tbl[2]  = '{4'b1100, 4'b1010, 3'b010, 4'b0110, 1'b0, 1'b0};
    tbl[3]  = '{4'b1100, 4'b1010, 3'b011, 4'b0111, 1'b0, 1'b1};
    tbl[4]  = '{4'b1100, 4'b1010, 3'b100, 4'b0001, 1'b0, 1'b1};
    tbl[5]  = '{4'b1100, 4'b1010, 3'b101, 4'b1001, 1'b0, 1'b0};
    tbl[6]  = '{4'b1100, 4'b1010, 3'b110, 4'b0011, 1'b0, 1'b0};
    tbl[7]  = '{4'b1100, 4'b1010, 3'b111, 4'b0100, 1'b0, 1'b1};
    tbl[8]  = '{4'b1111, 4'b0000, 3'b000, 4'b0000, 1'b1, 1'b0};
    tbl[9]  = '{4'b1010, 4'b1111, 3'b000, 4'b1010, 1'b0, 1'b0};
    tbl[10] = '{4'b1000, 4'b1111, 3'b000, 4'b1000, 1'b0, 1'b1};

    rst_n = 1'b0;
    iv    = 3'b000;
    ordy  = 3'b111;
    for (int d = 0; d < 3; d++) begin
      a_s[d] = 64'd0; b_s[d] = 64'd0; op_s[d] = 3'd0;
      cnt[d] = 0; prev_stall[d] = 1'b0; prev_r[d] = 64'd0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_out_valid", {63'd0, ov[d]}, 64'd0);
      chk("reset_r", rout(d), 64'd0);
      chk("reset_xfer_count", {48'd0, xc[d]}, 64'd0);
      chk("reset_in_ready", {63'd0, ir[d]}, 64'd1);
    end
    tick();

    // Op sweep and flag vectors, back-to-back: each result 2 cycles after acceptance.
    for (int i = 0; i < 13; i++) begin
      if (i < 11) begin
        iv[0] = 1'b1;
        drive0(tbl[i].a, tbl[i].b, tbl[i].op);
      end else begin
        iv[0] = 1'b0;
      end
      #1;
      chk("sweep_in_ready", {63'd0, ir[0]}, 64'd1);
      if (i >= 2) begin
        chk("sweep_out_valid", {63'd0, ov[0]}, 64'd1);
        chk("sweep_r", rout(0), {60'd0, tbl[i-2].r});
`ifdef LOGIC_UNIT_FLAGS_EN
        chk("sweep_zero", {63'd0, zf[0]}, {63'd0, tbl[i-2].z});
        chk("sweep_parity", {63'd0, pf[0]}, {63'd0, tbl[i-2].p});
`endif
      end else begin
        chk("sweep_latency_idle", {63'd0, ov[0]}, 64'd0);
      end
      tick();
    end
    chk("sweep_idle_after", {63'd0, ov[0]}, 64'd0);

    // Backpressure: two accepted, third refused, first result held.
    ordy[0] = 1'b0;
    iv[0] = 1'b1; drive0(4'b1100, 4'b1010, 3'b000); #1;
    chk("bp_accept_1", {63'd0, ir[0]}, 64'd1);
    tick();
    drive0(4'b1100, 4'b1010, 3'b001); #1;
    chk("bp_accept_2", {63'd0, ir[0]}, 64'd1);
    tick();
    drive0(4'b1100, 4'b1010, 3'b010); #1;
    chk("bp_full_in_ready", {63'd0, ir[0]}, 64'd0);
    chk("bp_hold_r", rout(0), 64'h8);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_stall_in_ready", {63'd0, ir[0]}, 64'd0);
      chk("bp_stall_valid", {63'd0, ov[0]}, 64'd1);
      chk("bp_stall_r", rout(0), 64'h8);
    end
    ordy[0] = 1'b1; #1;
    chk("bp_full_pass_ready", {63'd0, ir[0]}, 64'd1);
    tick();
    iv[0] = 1'b0;
    chk("bp_drain_b", rout(0), 64'hE);
    chk("bp_drain_b_valid", {63'd0, ov[0]}, 64'd1);
    tick();
    chk("bp_drain_c", rout(0), 64'h6);
    chk("bp_drain_c_valid", {63'd0, ov[0]}, 64'd1);
    tick();
    chk("bp_empty", {63'd0, ov[0]}, 64'd0);
    chk("bp_count", {48'd0, xc[0]}, 64'd14);

    // Reset with two entries in flight.
    ordy[0] = 1'b0;
    iv[0] = 1'b1; drive0(4'b1111, 4'b0110, 3'b001); tick();
    drive0(4'b0011, 4'b0101, 3'b010); tick();
    iv[0] = 1'b0; #1;
    chk("mid_inflight_valid", {63'd0, ov[0]}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, ov[0]}, 64'd0);
    chk("mid_rst_r", rout(0), 64'd0);
    chk("mid_rst_count", {48'd0, xc[0]}, 64'd0);
    tick();
    rst_n = 1'b1;
    ordy[0] = 1'b1; #1;
    chk("mid_release_ready", {63'd0, ir[0]}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_no_stale", {63'd0, ov[0]}, 64'd0);
    end

    // Counter wrap: 65537 transfers.
    iv[0] = 1'b1; ordy[0] = 1'b1; drive0(4'b1010, 4'b0110, 3'b010);
    n = 0; seen_ffff = 1'b0; seen_0001 = 1'b0;
    for (int c = 0; c < 66000 && !seen_0001; c++) begin
      #1;
      if (n == 65535 && !seen_ffff) begin
        chk("wrap_ffff", {48'd0, xc[0]}, 64'hFFFF);
        seen_ffff = 1'b1;
      end
      if (n == 65537) begin
        chk("wrap_0001", {48'd0, xc[0]}, 64'h0001);
        seen_0001 = 1'b1;
      end else begin
        if (ov[0] && ordy[0]) n++;
        tick();
      end
    end
    if (!seen_0001) chk("wrap_timeout", 64'd0, 64'd1);
    iv[0] = 1'b0;

    // Random runs on all three configurations against the queue model.
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    for (int c = 0; c < 1520; c++) begin
      for (int d = 0; d < 3; d++) begin
        if (c < 1500) begin
          iv[d]   = ($urandom_range(0, 9) < 7);
          a_s[d]  = {$urandom, $urandom};
          b_s[d]  = {$urandom, $urandom};
          op_s[d] = 3'($urandom_range(0, 7));
          ordy[d] = 1'($urandom_range(0, 1));
        end else begin
          iv[d]   = 1'b0;
          ordy[d] = 1'b1;
        end
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        chk("rnd_in_ready", {63'd0, ir[d]},
            {63'd0, (mq[d].size() < st(d)) || ordy[d]});
        if (prev_stall[d]) begin
          chk("rnd_hold_valid", {63'd0, ov[d]}, 64'd1);
          chk("rnd_hold_r", rout(d), prev_r[d]);
        end
        if (ov[d] && ordy[d]) begin
          if (mq[d].size() == 0) begin
            chk("rnd_spurious_output", 64'd1, 64'd0);
          end else begin
            chk("rnd_r", rout(d), mq[d].pop_front());
            cnt[d]++;
          end
        end
        if (iv[d] && ir[d]) mq[d].push_back(ref_op(a_s[d], b_s[d], op_s[d], wd(d)));
        prev_stall[d] = ov[d] && !ordy[d];
        prev_r[d]     = rout(d);
      end
      tick();
    end
    for (int d = 0; d < 3; d++) begin
      chk("rnd_all_delivered", 64'(mq[d].size()), 64'd0);
      chk("rnd_xfer_count", {48'd0, xc[d]}, 64'(cnt[d] % 65536));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
